eth_decap: RTL and testbench

//  Receive side of the PCIe TLP capture tunnel, running on clk156.
//  - Accepts Eth+IPv4+UDP+TCAP frames from the 10G MAC RX AXI-Stream.
//  - Checks the fixed 48-byte header (6 beats) against the configured addresses, ports and TCAP version.
//  - Strips the header and writes the TLP payload beats into the TLP FIFO, 74-bit {tkeep,tdata,tlast,tuser}.

---
 rtl/eth_decap_if.sv | 23 ++
 rtl/eth_decap.sv | 155 +++++++++++++++
 tb/tb_eth_decap.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_decap_if.sv
// Bundles the MAC RX AXI-Stream and the TLP FIFO write port of eth_decap.
// slave = the decapsulator side, master = the MAC/FIFO (environment) side.
interface eth_decap_if;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [63:0] s_axis_tdata;
   logic [7:0]  s_axis_tkeep;
   logic        s_axis_tlast;
   logic        s_axis_tuser;
   logic        wr_en;
   logic [73:0] din;
   logic        full;

   modport slave (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, full,
      output s_axis_tready, wr_en, din
   );

   modport master (
      output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, full,
      input  s_axis_tready, wr_en, din
   );
endinterface

// File: rtl/eth_decap.sv
// TLP tunnel receiver: validates the 48-byte Eth/IPv4/UDP/TCAP header and forwards the payload
// beats to the TLP FIFO. Optional feature macro: RX_SEQ_CHECK_EN (adds the cnt_gap counter).
module eth_decap #(
   parameter logic [47:0] eth_addr  = 48'h00_11_22_33_44_55,
   parameter logic [31:0] ip_addr   = {8'd192, 8'd168, 8'd11, 8'd1},
   parameter logic [15:0] udp_dport = 16'h3776,
   parameter logic [2:0]  tcap_ver  = 3'b001,
   parameter int          hdr_beats = 6
) (
   input  logic        clk156,
   input  logic        sys_rst,
   eth_decap_if.slave  bus,
   output logic [39:0] rx_seq,
   output logic [31:0] cnt_ok,
`ifdef RX_SEQ_CHECK_EN
   output logic [31:0] cnt_drop,
   output logic [31:0] cnt_gap
`else
   output logic [31:0] cnt_drop
`endif
);

   localparam logic [15:0] eth_p_ip  = 16'h0800;
   localparam logic [7:0]  ip_vihl   = 8'h45;
   localparam logic [7:0]  ip_p_udp  = 8'd17;
   localparam logic [2:0]  last_hdr  = 3'(hdr_beats - 1);

   typedef enum logic [1:0] {RX_HDR, RX_DATA, RX_DROP} state_t;

   state_t                      state, state_nx;
   logic [2:0]                  cnt;
   logic [(hdr_beats-1)*64-1:0] hdr;
   logic                        hdr_err;
   logic [63:0]                 data_c;
   logic [7:0]                  keep_c;
   logic [hdr_beats*64-1:0]     hdr_full;
   logic                        xfer, hdr_ok, accept, inc_ok, inc_drop;
   logic                        unused_hdr;

   // Network order: MAC byte0 moves to the top byte, tkeep bit0 to bit7.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         data_c[63-8*i -: 8] = bus.s_axis_tdata[8*i +: 8];
         keep_c[7-i]         = bus.s_axis_tkeep[i];
      end
   end

   // The last header beat is checked while it is still on the bus, so it is appended unregistered.
   assign hdr_full = {hdr, data_c};
   assign xfer     = bus.s_axis_tvalid && bus.s_axis_tready;
   assign hdr_ok   = (hdr_full[383:336] == eth_addr || hdr_full[383:336] == 48'hFFFF_FFFF_FFFF)
                  && hdr_full[287:272] == eth_p_ip
                  && hdr_full[271:264] == ip_vihl
                  && hdr_full[199:192] == ip_p_udp
                  && hdr_full[143:112] == ip_addr
                  && hdr_full[95:80]   == udp_dport
                  && hdr_full[47:45]   == tcap_ver;
   assign unused_hdr = ^hdr_full;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx          = state;
      bus.s_axis_tready = 1'b0;
      bus.wr_en         = 1'b0;
      bus.din           = '0;
      accept            = 1'b0;
      inc_ok            = 1'b0;
      inc_drop          = 1'b0;
      case (state)
         RX_HDR: begin
            bus.s_axis_tready = 1'b1;
            if (xfer) begin
               if (bus.s_axis_tlast) begin
                  inc_drop = 1'b1;
               end else if (cnt == last_hdr) begin
                  if (hdr_ok && !hdr_err && !bus.s_axis_tuser) begin
                     accept   = 1'b1;
                     state_nx = RX_DATA;
                  end else begin
                     state_nx = RX_DROP;
                  end
               end
            end
         end
         RX_DATA: begin
            bus.s_axis_tready = !bus.full;
            bus.wr_en         = xfer;
            bus.din           = {keep_c, data_c, bus.s_axis_tlast, bus.s_axis_tuser};
            if (xfer && bus.s_axis_tlast) begin
               inc_ok   = 1'b1;
               state_nx = RX_HDR;
            end
         end
         RX_DROP: begin
            bus.s_axis_tready = 1'b1;
            if (xfer && bus.s_axis_tlast) begin
               inc_drop = 1'b1;
               state_nx = RX_HDR;
            end
         end
         default: state_nx = RX_HDR;
      endcase
      if (sys_rst) begin
         bus.s_axis_tready = 1'b0;
         bus.wr_en         = 1'b0;
         bus.din           = '0;
         accept            = 1'b0;
         inc_ok            = 1'b0;
         inc_drop          = 1'b0;
      end
   end

`ifdef RX_SEQ_CHECK_EN
   logic seen;
`endif

   // NOTE: registers use non-blocking assignments only; reset is synchronous and active-high.
   always_ff @(posedge clk156) begin
      if (sys_rst) begin
         state    <= RX_HDR;
         cnt      <= '0;
         hdr      <= '0;
         hdr_err  <= 1'b0;
         rx_seq   <= '0;
         cnt_ok   <= '0;
         cnt_drop <= '0;
`ifdef RX_SEQ_CHECK_EN
         cnt_gap  <= '0;
         seen     <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         if (state == RX_HDR && xfer) begin
            hdr <= {hdr[(hdr_beats-2)*64-1:0], data_c};
            if (bus.s_axis_tlast || cnt == last_hdr) begin
               cnt     <= '0;
               hdr_err <= 1'b0;
            end else begin
               cnt     <= cnt + 3'd1;
               hdr_err <= hdr_err | bus.s_axis_tuser;
            end
         end
         if (accept) begin
            rx_seq <= hdr_full[39:0];
`ifdef RX_SEQ_CHECK_EN
            seen <= 1'b1;
            if (seen && hdr_full[39:0] != rx_seq + 40'd1) cnt_gap <= cnt_gap + 32'd1;
`endif
         end
         if (inc_ok)   cnt_ok   <= cnt_ok + 32'd1;
         if (inc_drop) cnt_drop <= cnt_drop + 32'd1;
      end
   end

endmodule

// File: tb/tb_eth_decap.sv
// Randomised bench for eth_decap: frames are built as byte arrays, a byte-level model decides
// accept/drop and the FIFO words each accepted frame must produce.
module tb_eth_decap;
   logic        clk156 = 1'b0;
   logic        sys_rst;
   logic [39:0] rx_seq;
   logic [31:0] cnt_ok, cnt_drop;
`ifdef RX_SEQ_CHECK_EN
   logic [31:0] cnt_gap;
`endif

   eth_decap_if bus();

   eth_decap dut (
      .clk156   (clk156),
      .sys_rst  (sys_rst),
      .bus      (bus),
      .rx_seq   (rx_seq),
      .cnt_ok   (cnt_ok),
`ifdef RX_SEQ_CHECK_EN
      .cnt_drop (cnt_drop),
      .cnt_gap  (cnt_gap)
`else
      .cnt_drop (cnt_drop)
`endif
   );

   always #5 clk156 = ~clk156;

   int n_chk = 0, n_pass = 0;
   int n_wr = 0;
   bit cap_first = 0;
   bit rand_full = 0, rand_gap = 0;
   logic [73:0] first_din;
   logic [73:0] exp_q[$];
   byte unsigned frm[$];

   // Model state
   int          exp_ok = 0, exp_drop = 0, exp_gap = 0;
   logic [39:0] exp_seq = '0;
   bit          first_acc = 1;

   task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Compare process: every FIFO write must match the next expected word.
   always @(negedge clk156) begin
      if (!sys_rst && bus.wr_en) begin
         n_wr++;
         if (cap_first) begin
            first_din = bus.din;
            cap_first = 0;
         end
         if (exp_q.size() == 0) check(1'b0, "unexpected_write", bus.din, 0);
         else begin
            logic [73:0] e;
            e = exp_q.pop_front();
            check(bus.din == e, "din", bus.din, e);
         end
      end else if (!sys_rst && bus.s_axis_tvalid && bus.s_axis_tready && exp_q.size() != 0) begin
         check(1'b0, "missing_write", 0, exp_q[0]);
      end
   end

   function automatic logic [39:0] frame_ts();
      return {frm[43], frm[44], frm[45], frm[46], frm[47]};
   endfunction

   function automatic bit model_accept(input int tuser_beat);
      logic [47:0] d;
      if (frm.size() <= 48) return 0;
      d = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
      if (d != 48'h0011_2233_4455 && d != 48'hFFFF_FFFF_FFFF) return 0;
      if (frm[12] != 8'h08 || frm[13] != 8'h00) return 0;
      if (frm[14] != 8'h45) return 0;
      if (frm[23] != 8'd17) return 0;
      if (frm[30] != 8'd192 || frm[31] != 8'd168 || frm[32] != 8'd11 || frm[33] != 8'd1) return 0;
      if ({frm[36], frm[37]} != 16'h3776) return 0;
      if (frm[42][7:5] != 3'b001) return 0;
      if (tuser_beat >= 0 && tuser_beat < 6) return 0;
      return 1;
   endfunction

   task automatic build_frame(input logic [47:0] dest, input logic [15:0] dport, input logic [2:0] ver,
                              input logic [39:0] ts, input int plen);
      frm.delete();
      for (int i = 0; i < 6; i++) frm.push_back(dest[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
      frm.push_back(8'h08); frm.push_back(8'h00);
      frm.push_back(8'h45); frm.push_back(8'h00);
      frm.push_back(8'(((plen + 34) >> 8))); frm.push_back(8'(plen + 34));
      for (int i = 0; i < 4; i++) frm.push_back(8'($urandom));
      frm.push_back(8'd64); frm.push_back(8'd17);
      frm.push_back(8'h00); frm.push_back(8'h00);
      for (int i = 0; i < 4; i++) frm.push_back(8'($urandom));
      frm.push_back(8'd192); frm.push_back(8'd168); frm.push_back(8'd11); frm.push_back(8'd1);
      frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
      frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
      frm.push_back(8'(((plen + 14) >> 8))); frm.push_back(8'(plen + 14));
      frm.push_back(8'h00); frm.push_back(8'h00);
      frm.push_back({ver, 5'($urandom)});
      for (int i = 0; i < 5; i++) frm.push_back(ts[39-8*i -: 8]);
      for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
   endtask

   task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u,
                            input int stall);
      bit rdy;
      int n;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = d;
      bus.s_axis_tkeep  = k;
      bus.s_axis_tlast  = l;
      bus.s_axis_tuser  = u;
      if (stall > 0) begin
         bus.full = 1'b1;
         repeat (stall) begin
            @(negedge clk156);
            check(bus.s_axis_tready == 1'b0, "stall_tready", bus.s_axis_tready, 0);
            @(posedge clk156); #1;
         end
         bus.full = 1'b0;
      end
      n = 0;
      do begin
         if (rand_full) bus.full = ($urandom_range(3) == 0);
         @(negedge clk156);
         rdy = bus.s_axis_tready;
         @(posedge clk156); #1;
         n++;
      end while (!rdy && n < 200);
      if (!rdy) check(1'b0, "handshake_timeout", n, 200);
      bus.s_axis_tvalid = 1'b0;
      bus.full          = 1'b0;
      if (rand_gap && $urandom_range(3) == 0) begin
         @(posedge clk156); #1;
      end
   endtask

   // Sends frm; stop_beat >= 0 abandons the frame before that beat (no model bookkeeping).
   task automatic send_frame(input int tuser_beat, input int stall_beat, input int stop_beat);
      int nb, len;
      bit acc;
      logic [39:0] ts;
      len = frm.size();
      nb  = (len + 7) / 8;
      acc = model_accept(tuser_beat);
      ts  = (len >= 48) ? frame_ts() : '0;
      for (int b = 0; b < nb; b++) begin
         logic [63:0] d, ed;
         logic [7:0]  k, ek;
         logic        l, u;
         if (b == stop_beat) return;
         d = '0; ed = '0; k = '0; ek = '0;
         for (int j = 0; j < 8; j++) begin
            if (8*b + j < len) begin
               d[8*j +: 8]    = frm[8*b + j];
               ed[63-8*j -: 8] = frm[8*b + j];
               k[j]           = 1'b1;
               ek[7-j]        = 1'b1;
            end
         end
         l = (b == nb - 1);
         u = (b == tuser_beat);
         if (acc && b >= 6) exp_q.push_back({ek, ed, l, u});
         send_beat(d, k, l, u, (b == stall_beat) ? 3 : 0);
      end
      if (acc) begin
         if (!first_acc && ts != 40'(exp_seq + 40'd1)) exp_gap++;
         first_acc = 0;
         exp_seq   = ts;
         exp_ok++;
      end else begin
         exp_drop++;
      end
   endtask

   task automatic frame_done_check();
      repeat (2) @(negedge clk156);
      check(cnt_ok == 32'(exp_ok), "cnt_ok", cnt_ok, exp_ok);
      check(cnt_drop == 32'(exp_drop), "cnt_drop", cnt_drop, exp_drop);
      check(rx_seq == exp_seq, "rx_seq", rx_seq, exp_seq);
`ifdef RX_SEQ_CHECK_EN
      check(cnt_gap == 32'(exp_gap), "cnt_gap", cnt_gap, exp_gap);
`endif
      check(exp_q.size() == 0, "pending_writes", exp_q.size(), 0);
      @(posedge clk156); #1;
   endtask

   task automatic good(input logic [39:0] ts, input int plen);
      build_frame(48'h0011_2233_4455, 16'h3776, 3'b001, ts, plen);
   endtask

   initial begin
      sys_rst = 1'b1;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = 64'hDEAD_BEEF_0123_4567;
      bus.s_axis_tkeep  = 8'hFF;
      bus.s_axis_tlast  = 1'b1;
      bus.s_axis_tuser  = 1'b0;
      bus.full          = 1'b0;
      repeat (3) @(posedge clk156);
      @(negedge clk156);
      check(bus.s_axis_tready == 1'b0, "rst_tready", bus.s_axis_tready, 0);
      check(bus.wr_en == 1'b0, "rst_wr_en", bus.wr_en, 0);
      check(bus.din == 74'd0, "rst_din", bus.din, 0);
      check(cnt_ok == 32'd0 && cnt_drop == 32'd0 && rx_seq == 40'd0, "rst_counters",
            {cnt_ok, cnt_drop, rx_seq}, 0);
      @(posedge clk156); #1;
      bus.s_axis_tvalid = 1'b0;
      sys_rst = 1'b0;
      @(posedge clk156); #1;

      // Default frame, ts=1, payload bytes 0..31
      good(40'd1, 32);
      for (int i = 0; i < 32; i++) frm[48+i] = 8'(i);
      n_wr = 0; cap_first = 1;
      send_frame(-1, -1, -1);
      frame_done_check();
      check(n_wr == 4, "t1_writes", n_wr, 4);
      check(first_din == {8'hFF, 64'h0001_0203_0405_0607, 2'b00}, "t1_first_din", first_din,
            {8'hFF, 64'h0001_0203_0405_0607, 2'b00});
      check(cnt_ok == 32'd1 && rx_seq == 40'd1, "t1_literal", {cnt_ok, rx_seq}, {32'd1, 40'd1});

      // Wrong UDP port, then a good frame
      build_frame(48'h0011_2233_4455, 16'h1234, 3'b001, 40'd2, 32);
      n_wr = 0;
      send_frame(-1, -1, -1);
      frame_done_check();
      check(n_wr == 0 && cnt_drop == 32'd1, "t2_literal", {n_wr, cnt_drop}, {32'd0, 32'd1});
      good(40'd2, 32); send_frame(-1, -1, -1); frame_done_check();

      // Runt: tlast on beat 3, then a good frame
      good(40'd3, 32);
      while (frm.size() > 32) void'(frm.pop_back());
      send_frame(-1, -1, -1); frame_done_check();
      good(40'd3, 32); send_frame(-1, -1, -1); frame_done_check();

      // full for 3 cycles on data beat 2
      good(40'd4, 32); send_frame(-1, 8, -1); frame_done_check();

      // tuser on header beat 2 -> drop; tuser on last data beat -> accepted with din[0]=1
      good(40'd5, 32); send_frame(2, -1, -1); frame_done_check();
      good(40'd5, 29); send_frame(9, -1, -1); frame_done_check();

      // Sequence gap (5 -> 7), then 40-bit wrap without gap
      good(40'd7, 16); send_frame(-1, -1, -1); frame_done_check();
`ifdef RX_SEQ_CHECK_EN
      check(cnt_gap == 32'd1, "gap_literal", cnt_gap, 1);
`endif
      good(40'hFF_FFFF_FFFF, 8); send_frame(-1, -1, -1); frame_done_check();
      good(40'd0, 8); send_frame(-1, -1, -1); frame_done_check();

      // Reset in the middle of the payload, then the frame tail and a good frame
      good(40'd50, 32);
      send_frame(-1, -1, 8);
      sys_rst = 1'b1;
      @(posedge clk156); #1;
      @(posedge clk156); #1;
      sys_rst = 1'b0;
      exp_ok = 0; exp_drop = 0; exp_gap = 0; exp_seq = '0; first_acc = 1;
      @(negedge clk156);
      check(cnt_ok == 32'd0 && cnt_drop == 32'd0 && rx_seq == 40'd0, "midrst_counters",
            {cnt_ok, cnt_drop, rx_seq}, 0);
      @(posedge clk156); #1;
      begin
         byte unsigned tail[$];
         for (int i = 64; i < frm.size(); i++) tail.push_back(frm[i]);
         frm = tail;
      end
      send_frame(-1, -1, -1); frame_done_check();
      good(40'd100, 24); send_frame(-1, -1, -1); frame_done_check();

      // Randomised frames with back-pressure and idle gaps
      rand_full = 1; rand_gap = 1;
      for (int f = 0; f < 40; f++) begin
         int kind, plen, tu, nb;
         logic [39:0] ts;
         ts   = ($urandom_range(1) == 0) ? 40'(exp_seq + 40'd1) : {8'($urandom), 32'($urandom)};
         plen = $urandom_range(1, 40);
         good(ts, plen);
         kind = $urandom_range(0, 14);
         tu   = -1;
         nb   = (frm.size() + 7) / 8;
         case (kind)
            4:  for (int i = 0; i < 6; i++) frm[i] = 8'hFF;
            5:  begin int p; p = $urandom_range(0, 5); frm[p] = frm[p] ^ 8'h10; end
            6:  frm[12] = frm[12] ^ 8'h01;
            7:  frm[14] = 8'h46;
            8:  frm[23] = 8'd6;
            9:  begin int p; p = $urandom_range(30, 33); frm[p] = frm[p] ^ 8'h04; end
            10: frm[37] = frm[37] ^ 8'h01;
            11: frm[42] = frm[42] ^ 8'h20;
            12: tu = $urandom_range(0, 5);
            13: begin int n; n = $urandom_range(1, 48); while (frm.size() > n) void'(frm.pop_back()); end
            14: tu = 6 + $urandom_range(0, nb - 7);
            default: ;
         endcase
         send_frame(tu, -1, -1);
         frame_done_check();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      check(1'b0, "global_timeout", 0, 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
